// File: rtl/rng_pkg.sv
// Shared types and defaults for the random-number arbiter and its round-robin picker.
package rng_pkg;

   localparam int unsigned DEF_NREQ   = 3;
   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned DEF_STEPS  = 4;
   localparam int unsigned STEP_CNT_W = 4;

   // Game requester slots
   localparam int unsigned REQ_SPAWN_X = 0;
   localparam int unsigned REQ_DIR     = 1;
   localparam int unsigned REQ_SPEED   = 2;

   // Only the flight-direction requester runs the LFSR backwards
   localparam logic [DEF_NREQ-1:0] DEF_DIR_MASK = DEF_NREQ'(1) << REQ_DIR;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STEP   = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_REDUCE = 3'd3,
      ST_DONE   = 3'd4
   } rng_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after the rr pointer wins.
module rr_pick
   import rng_pkg::*;
#(
   parameter int unsigned NREQ = DEF_NREQ,
   parameter int unsigned IDXW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] rr,
   output logic            valid_c,
   output logic [IDXW-1:0] winner_c
);

   logic [NREQ-1:0] rot;
   int              sum;

   // Rotate so the rr position lands at bit 0; the lowest set bit is the winner
   always_comb begin
      rot      = NREQ'({req, req} >> rr);
      sum      = 0;
      winner_c = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum      = int'(rr) + k;
            winner_c = IDXW'((sum >= int'(NREQ)) ? (sum - int'(NREQ)) : sum);
         end
      end
   end

   assign valid_c = |req;

endmodule

// File: rtl/rng_arbiter.sv
// Shares one LFSR between NREQ requesters: steps it, samples it, reduces modulo limit, acks.
module rng_arbiter
   import rng_pkg::*;
#(
   parameter int unsigned     NREQ     = DEF_NREQ,
   parameter int unsigned     WIDTH    = DEF_WIDTH,
   parameter int unsigned     STEPS    = DEF_STEPS,
   parameter logic [NREQ-1:0] DIR_MASK = NREQ'(DEF_DIR_MASK)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] limit,
   input  logic                  free_run,
   input  logic [WIDTH-1:0]      lfsr_count,
   output logic                  lfsr_enable,
   output logic                  lfsr_up_down,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      rnd_data,
   output logic                  busy
);

   localparam int unsigned IDXW = idx_width(NREQ);

   rng_state_e            state;
   logic [IDXW-1:0]       rr;
   logic [IDXW-1:0]       g;
   logic [WIDTH-1:0]      lim;
   logic [WIDTH-1:0]      rem;
   logic [STEP_CNT_W-1:0] step_cnt;

   logic                  pick_valid;
   logic [IDXW-1:0]       pick_idx;

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_pick (
      .req      (req),
      .rr       (rr),
      .valid_c  (pick_valid),
      .winner_c (pick_idx)
   );

   // Sequencer; every output is set for the state being entered so it is Moore and registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         rr           <= '0;
         g            <= '0;
         lim          <= '0;
         rem          <= '0;
         step_cnt     <= '0;
         ack          <= '0;
         rnd_data     <= '0;
         busy         <= 1'b0;
         lfsr_enable  <= 1'b0;
         lfsr_up_down <= 1'b0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  g            <= pick_idx;
                  lim          <= limit[int'(pick_idx)*WIDTH +: WIDTH];
                  step_cnt     <= '0;
                  state        <= ST_STEP;
                  busy         <= 1'b1;
                  lfsr_enable  <= 1'b1;
                  lfsr_up_down <= DIR_MASK[pick_idx];
               end else begin
                  lfsr_enable  <= free_run;
                  lfsr_up_down <= 1'b0;
               end
            end
            ST_STEP: begin
               if (step_cnt == STEP_CNT_W'(STEPS - 1)) begin
                  state        <= ST_SAMPLE;
                  lfsr_enable  <= 1'b0;
                  lfsr_up_down <= 1'b0;
               end else begin
                  step_cnt <= step_cnt + STEP_CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               rem   <= lfsr_count;
               state <= ST_REDUCE;
            end
            // Modulo by repeated subtraction; the guard keeps rem - lim from underflowing
            ST_REDUCE: begin
               if ((lim == '0) || (rem < lim)) begin
                  state    <= ST_DONE;
                  ack      <= NREQ'(1) << g;
                  rnd_data <= rem;
               end else begin
                  rem <= rem - lim;
               end
            end
            ST_DONE: begin
               rr           <= (g == IDXW'(NREQ - 1)) ? '0 : g + IDXW'(1);
               state        <= ST_IDLE;
               busy         <= 1'b0;
               lfsr_enable  <= free_run;
               lfsr_up_down <= 1'b0;
            end
            default: begin
               state        <= ST_IDLE;
               busy         <= 1'b0;
               lfsr_enable  <= 1'b0;
               lfsr_up_down <= 1'b0;
            end
         endcase
      end
   end

endmodule
